key_event_tx: RTL

- Parametrised successor to the fixed 40-key, full-vector key report sent to the PC.
- Debounces an N_KEYS-wide key_down vector on camera frame ticks.
- Two output modes, selected at run time:
  - event mode: one byte per debounced press or release, queued in a FIFO;
  - snapshot mode: the full key bitmap, sent once per frame.
- Sits between the camera key detector and the UART byte sender, using a valid/ready byte handshake.

---
 rtl/capiano_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 57 +++++
 rtl/key_event_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/capiano_pkg.sv
`default_nettype none
// ============================================================================
// Package     : capiano_pkg
// Description : Shared constants, the output FSM encoding and a clog2 helper
//               for the key report path.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package capiano_pkg;

    localparam logic [7:0] SNAP_HDR      = 8'hFF;
    localparam int         EVT_PRESS_BIT = 7;
    localparam int         KEY_IDX_W     = 7;

    typedef logic [1:0] tx_state_t;
    localparam tx_state_t ST_IDLE      = 2'd0;
    localparam tx_state_t ST_EVT       = 2'd1;
    localparam tx_state_t ST_SNAP_HDR  = 2'd2;
    localparam tx_state_t ST_SNAP_BODY = 2'd3;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : capiano_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : 8-bit single-clock FIFO, power-of-two depth, show-ahead head.
//               rst is synchronous and active-low like the rest of capiano.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import capiano_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int c_AW = clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Extra pointer bit tells a full ring from an empty one.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule : sync_fifo
`default_nettype wire

// File: rtl/key_event_tx.sv
`default_nettype none
// ============================================================================
// Module      : key_event_tx
// Description : Debounces the camera key vector and reports it to the UART
//               sender as per-key press/release events or per-frame bitmaps.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module key_event_tx
    import capiano_pkg::*;
#(
    parameter int N_KEYS     = 40,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic [N_KEYS-1:0] key_down,
    input  logic              snap_mode,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [N_KEYS-1:0] stable_keys,
    output logic              coalesced
);

    localparam int c_CNT_W = (clog2(DEBOUNCE) < 1) ? 1 : clog2(DEBOUNCE);
    localparam int c_IDX_W = (clog2(N_KEYS) < 1) ? 1 : clog2(N_KEYS);
    localparam int c_NB    = (N_KEYS + 7) / 8;
    localparam int c_BUF_W = c_NB * 8;
    localparam int c_B_W   = (clog2(c_NB) < 1) ? 1 : clog2(c_NB);

    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(N_KEYS - 1);
    localparam logic [c_B_W-1:0]   c_LAST_BYTE = c_B_W'(c_NB - 1);

    logic [N_KEYS-1:0]  r_stable;
    logic [N_KEYS-1:0]  r_pending;
    logic [N_KEYS-1:0]  w_flip;
    logic [N_KEYS-1:0]  w_set;
    logic [N_KEYS-1:0]  w_clr;
    logic               r_coalesced;

    logic [c_IDX_W-1:0] r_scan_idx;
    logic               w_push;
    logic               w_hold;
    logic [7:0]         w_evt_byte;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic [7:0]         w_fifo_dout;

    tx_state_t          r_state;
    logic               r_snap_req;
    logic [c_BUF_W-1:0] r_snap_buf;
    logic [c_B_W-1:0]   r_byte_idx;
    logic [c_B_W-1:0]   w_byte_next;
    logic [7:0]         w_snap_byte;
    logic               r_tx_valid;
    logic [7:0]         r_tx_data;
    logic               w_xfer;

    // Per-key debounce: count consecutive ticks that disagree with stable.
    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_differ;

        assign w_differ  = (key_down[k] != r_stable[k]);
        assign w_flip[k] = frame_tick && w_differ &&
                           ((32'(r_cnt) + 32'd1) == 32'(DEBOUNCE));

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_cnt <= '0;
            end else if (frame_tick) begin
                if (!w_differ || w_flip[k]) r_cnt <= '0;
                else                        r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_hold = r_pending[r_scan_idx] && w_fifo_full;
    assign w_push = r_pending[r_scan_idx] && !w_fifo_full;
    assign w_clr  = w_push ? (N_KEYS'(1) << r_scan_idx) : '0;
    assign w_set  = w_flip & {N_KEYS{~snap_mode}};

    always_comb begin
        w_evt_byte                = 8'(r_scan_idx);
        w_evt_byte[EVT_PRESS_BIT] = r_stable[r_scan_idx];
    end

    // A flip landing on an already pending key merges; set beats clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stable    <= '0;
            r_pending   <= '0;
            r_coalesced <= 1'b0;
            r_scan_idx  <= '0;
        end else begin
            r_stable  <= r_stable ^ w_flip;
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (|(w_flip & r_pending & ~w_clr)) r_coalesced <= 1'b1;
            if (!w_hold) begin
                r_scan_idx <= (r_scan_idx == c_LAST_IDX) ? '0 : r_scan_idx + 1'b1;
            end
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_evt_byte),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_xfer      = r_tx_valid && tx_ready;
    assign w_pop       = (r_state == ST_EVT) && w_xfer;
    assign w_byte_next = (r_state == ST_SNAP_HDR) ? '0 : r_byte_idx + 1'b1;
    assign w_snap_byte = r_snap_buf[{w_byte_next, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_snap_req <= 1'b0;
            r_snap_buf <= '0;
            r_byte_idx <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_state    <= ST_EVT;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_fifo_dout;
                    end else if (r_snap_req) begin
                        r_state    <= ST_SNAP_HDR;
                        r_snap_buf <= c_BUF_W'(r_stable);
                        r_snap_req <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= SNAP_HDR;
                    end
                end
                ST_EVT: begin
                    if (w_xfer) begin
                        r_state    <= ST_IDLE;
                        r_tx_valid <= 1'b0;
                    end
                end
                ST_SNAP_HDR: begin
                    if (w_xfer) begin
                        r_state    <= ST_SNAP_BODY;
                        r_byte_idx <= '0;
                        r_tx_data  <= w_snap_byte;
                    end
                end
                ST_SNAP_BODY: begin
                    if (w_xfer) begin
                        if (r_byte_idx == c_LAST_BYTE) begin
                            r_state    <= ST_IDLE;
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_byte_idx <= w_byte_next;
                            r_tx_data  <= w_snap_byte;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                end
            endcase
            // A new frame request outranks the clear on header entry.
            if (frame_tick && snap_mode) r_snap_req <= 1'b1;
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign stable_keys = r_stable;
    assign coalesced   = r_coalesced;

endmodule : key_event_tx
`default_nettype wire
